// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order branch queue snooping CDB operands; in_* enqueue, cdb_* capture, out_* resolved head, count occupancy
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CDB_NUM = 2,
  parameter int RSID_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_kind,
  input  logic [31:0]                    in_pc,
  input  logic [31:0]                    in_target,
  input  logic                           in_pred_taken,
  input  logic [31:0]                    in_pred_target,
  input  logic                           in_op1_is_rsid,
  input  logic                           in_op2_is_rsid,
  input  logic [31:0]                    in_op1,
  input  logic [31:0]                    in_op2,
  input  logic [CDB_NUM-1:0]             cdb_valid,
  input  logic [CDB_NUM*RSID_WIDTH-1:0]  cdb_rsid,
  input  logic [CDB_NUM*32-1:0]          cdb_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_pc,
  output logic                           out_taken,
  output logic [31:0]                    out_target,
  output logic                           out_mispredict,
  output logic [$clog2(DEPTH):0]         count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0] v, r1, r2, pt;
  logic [2:0] kind [DEPTH];
  logic [31:0] pc [DEPTH];
  logic [31:0] tgt [DEPTH];
  logic [31:0] ptg [DEPTH];
  logic [31:0] op1 [DEPTH];
  logic [31:0] op2 [DEPTH];
  logic [32:0] s1 [DEPTH];
  logic [32:0] s2 [DEPTH];
  logic [32:0] e1, e2;
  logic [AW-1:0] wp, rp;
  logic enq, deq, tk, hv;
  logic [2:0] hk;
  logic [31:0] a, b, nt;
  function automatic logic [32:0] snoop(
    input logic [RSID_WIDTH-1:0] id,
    input logic [CDB_NUM-1:0] cv,
    input logic [CDB_NUM*RSID_WIDTH-1:0] cr,
    input logic [CDB_NUM*32-1:0] cd
  );
    snoop = '0;
    for (int i = CDB_NUM - 1; i >= 0; i--)
      if (cv[i] && cr[i*RSID_WIDTH +: RSID_WIDTH] == id) snoop = {1'b1, cd[i*32 +: 32]};
  endfunction
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s1[i] = snoop(op1[i][RSID_WIDTH-1:0], cdb_valid, cdb_rsid, cdb_data);
      s2[i] = snoop(op2[i][RSID_WIDTH-1:0], cdb_valid, cdb_rsid, cdb_data);
    end
  end
  assign e1 = snoop(in_op1[RSID_WIDTH-1:0], cdb_valid, cdb_rsid, cdb_data);
  assign e2 = snoop(in_op2[RSID_WIDTH-1:0], cdb_valid, cdb_rsid, cdb_data);
  assign in_ready = count < CW'(DEPTH);
  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;
  assign hk = kind[rp];
  assign a = op1[rp];
  assign b = op2[rp];
  // op2 only matters for the two-operand compares EQ/NE
  assign hv = v[rp] && r1[rp] && (hk > 3'd1 || r2[rp]);
  assign out_valid = hv;
  always_comb begin
    tk = hk == 3'd0 ? a == b :
         hk == 3'd1 ? a != b :
         hk == 3'd2 ? $signed(a) > 32'sd0 :
         hk == 3'd3 ? $signed(a) <= 32'sd0 :
         hk == 3'd4 ? a[31] :
         hk == 3'd5 ? !a[31] :
         hk == 3'd6;
    nt = hk == 3'd6 ? a : tk ? tgt[rp] : pc[rp] + 32'd4;
    out_pc = hv ? pc[rp] : '0;
    out_taken = hv && tk;
    out_target = hv ? nt : '0;
    out_mispredict = hv && ((tk != pt[rp]) || (tk && nt != ptg[rp]));
  end
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      v <= '0;
      r1 <= '0;
      r2 <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && wp == AW'(i)) begin
          v[i] <= 1'b1;
          kind[i] <= in_kind;
          pc[i] <= in_pc;
          tgt[i] <= in_target;
          pt[i] <= in_pred_taken;
          ptg[i] <= in_pred_target;
          op1[i] <= in_op1_is_rsid && e1[32] ? e1[31:0] : in_op1;
          op2[i] <= in_op2_is_rsid && e2[32] ? e2[31:0] : in_op2;
          r1[i] <= !in_op1_is_rsid || e1[32];
          r2[i] <= !in_op2_is_rsid || e2[32];
        end else begin
          if (deq && rp == AW'(i)) v[i] <= 1'b0;
          if (v[i] && !r1[i] && s1[i][32]) begin
            op1[i] <= s1[i][31:0];
            r1[i] <= 1'b1;
          end
          if (v[i] && !r2[i] && s2[i][32]) begin
            op2[i] <= s2[i][31:0];
            r2[i] <= 1'b1;
          end
        end
      end
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        mp;
  } exp_t;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_pred_taken, in_op1_is_rsid, in_op2_is_rsid;
  logic [2:0] in_kind;
  logic [31:0] in_pc, in_target, in_pred_target, in_op1, in_op2;
  logic [1:0] cdb_valid;
  logic [7:0] cdb_rsid;
  logic [63:0] cdb_data;
  logic out_valid, out_ready, out_taken, out_mispredict;
  logic [31:0] out_pc, out_target;
  logic [2:0] count;
  exp_t sbq[$];
  int compared = 0;
  int mism = 0;
  branch_resolve_queue #(.DEPTH(4), .CDB_NUM(2), .RSID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_pc(in_pc), .in_target(in_target), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_op1_is_rsid(in_op1_is_rsid), .in_op2_is_rsid(in_op2_is_rsid),
    .in_op1(in_op1), .in_op2(in_op2), .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_taken(out_taken),
    .out_target(out_target), .out_mispredict(out_mispredict), .count(count)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [2:0] k, input logic [31:0] p, t, input logic pk,
                                 input logic [31:0] pg, x, y);
    exp_t r;
    r.pc = p;
    case (k)
      3'd0: r.tk = x == y;
      3'd1: r.tk = x != y;
      3'd2: r.tk = $signed(x) > 0;
      3'd3: r.tk = $signed(x) <= 0;
      3'd4: r.tk = x[31];
      3'd5: r.tk = !x[31];
      3'd6: r.tk = 1'b1;
      default: r.tk = 1'b0;
    endcase
    r.tgt = k == 3'd6 ? x : r.tk ? t : p + 32'd4;
    r.mp = (r.tk != pk) || (r.tk && r.tgt != pg);
    return r;
  endfunction
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      exp_t e;
      compared++;
      if (sbq.size() == 0) begin
        mism++;
        $display("FAIL sb_unexpected: got pc=%h tgt=%h, want no output", out_pc, out_target);
      end else begin
        e = sbq.pop_front();
        if ({out_pc, out_taken, out_target, out_mispredict} !== {e.pc, e.tk, e.tgt, e.mp}) begin
          mism++;
          $display("FAIL sb_result: got pc=%h tk=%b tgt=%h mp=%b, want pc=%h tk=%b tgt=%h mp=%b",
                   out_pc, out_taken, out_target, out_mispredict, e.pc, e.tk, e.tgt, e.mp);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [2:0] k, input logic [31:0] p, t, input logic pk, input logic [31:0] pg,
                     input logic i1, input logic [31:0] o1, input logic i2, input logic [31:0] o2,
                     input logic [31:0] v1, v2, input logic push);
    in_valid = 1'b1;
    in_kind = k;
    in_pc = p;
    in_target = t;
    in_pred_taken = pk;
    in_pred_target = pg;
    in_op1_is_rsid = i1;
    in_op1 = o1;
    in_op2_is_rsid = i2;
    in_op2 = o2;
    if (push) sbq.push_back(model(k, p, t, pk, pg, v1, v2));
  endtask
  task automatic drain();
    int n = 0;
    while ((count !== 3'd0 || sbq.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    compared++;
    if (count !== 3'd0 || sbq.size() != 0) begin
      mism++;
      $display("FAIL drain: count=%0d pending=%0d, want 0/0", count, sbq.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    put(3'd0, 32'h10, 32'h20, 1'b0, 32'h14, 1'b0, 32'd1, 1'b0, 32'd1, 32'd1, 32'd1, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
      mism++;
      $display("FAIL reset_state: got ov=%b ir=%b cnt=%0d, want 0 1 0", out_valid, in_ready, count);
    end
    compared++;
    if ({out_pc, out_target, out_taken, out_mispredict} !== 66'd0) begin
      mism++;
      $display("FAIL reset_outs: got pc=%h tgt=%h tk=%b mp=%b, want zeros", out_pc, out_target, out_taken, out_mispredict);
    end
    tick();
  endtask
  task automatic test_beq();
    out_ready = 1'b1;
    put(3'd0, 32'h100, 32'h200, 1'b0, 32'h104, 1'b0, 32'd5, 1'b0, 32'd5, 32'd5, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, out_taken, out_target, out_mispredict} !== {1'b1, 1'b1, 32'h200, 1'b1}) begin
      mism++;
      $display("FAIL beq: got ov=%b tk=%b tgt=%h mp=%b, want 1 1 00000200 1", out_valid, out_taken, out_target, out_mispredict);
    end
    tick();
    drain();
  endtask
  task automatic test_cdb_capture();
    out_ready = 1'b1;
    put(3'd4, 32'h180, 32'h240, 1'b1, 32'h240, 1'b1, 32'd3, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
        mism++;
        $display("FAIL cdb_early%0d: got ov=%b, want 0", i, out_valid);
      end
      if (i == 0) tick();
    end
    cdb_valid = 2'b01;
    cdb_rsid = 8'h03;
    cdb_data = {32'd0, 32'hFFFFFFFF};
    tick();
    cdb_valid = 2'b00;
    @(negedge clk);
    compared++;
    if ({out_valid, out_taken} !== 2'b11) begin
      mism++;
      $display("FAIL cdb_capture: got ov=%b tk=%b, want 1 1", out_valid, out_taken);
    end
    tick();
    drain();
  endtask
  task automatic test_bypass();
    out_ready = 1'b1;
    put(3'd6, 32'h300, 32'h0, 1'b1, 32'h4000, 1'b1, 32'd2, 1'b0, 32'd0, 32'h4000, 32'd0, 1'b1);
    cdb_valid = 2'b11;
    cdb_rsid = {4'd2, 4'd5};
    cdb_data = {32'h4000, 32'h1234};
    tick();
    in_valid = 1'b0;
    cdb_valid = 2'b00;
    @(negedge clk);
    compared++;
    if ({out_valid, out_taken, out_target} !== {1'b1, 1'b1, 32'h4000}) begin
      mism++;
      $display("FAIL bypass: got ov=%b tk=%b tgt=%h, want 1 1 00004000", out_valid, out_taken, out_target);
    end
    tick();
    put(3'd6, 32'h340, 32'h0, 1'b1, 32'h4000, 1'b1, 32'd2, 1'b0, 32'd0, 32'h8000, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    cdb_valid = 2'b11;
    cdb_rsid = {4'd2, 4'd2};
    cdb_data = {32'h4000, 32'h8000};
    tick();
    cdb_valid = 2'b00;
    @(negedge clk);
    compared++;
    if (out_target !== 32'h8000) begin
      mism++;
      $display("FAIL cdb_priority: got tgt=%h, want 00008000", out_target);
    end
    tick();
    drain();
  endtask
  task automatic test_full_wrap();
    out_ready = 1'b1;
    put(3'd5, 32'h1000, 32'h1100, 1'b0, 32'h1004, 1'b1, 32'd7, 1'b0, 32'd0, 32'd5, 32'd0, 1'b1);
    tick();
    for (int i = 1; i < 4; i++) begin
      put(3'd0, 32'h1000 + i * 16, 32'h2000 + i, 1'b0, 32'h0, 1'b0, i, 1'b0, 32'd2, i, 32'd2, 1'b1);
      tick();
    end
    put(3'd1, 32'h1040, 32'h3000, 1'b1, 32'h3000, 1'b0, 32'd9, 1'b0, 32'd8, 32'd9, 32'd8, 1'b1);
    @(negedge clk);
    compared++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b0}) begin
      mism++;
      $display("FAIL full: got cnt=%0d ir=%b ov=%b, want 4 0 0", count, in_ready, out_valid);
    end
    tick();
    @(negedge clk);
    compared++;
    if (count !== 3'd4) begin
      mism++;
      $display("FAIL full_hold: got cnt=%0d, want 4", count);
    end
    cdb_valid = 2'b01;
    cdb_rsid = 8'h07;
    cdb_data = {32'd0, 32'd5};
    tick();
    cdb_valid = 2'b00;
    @(negedge clk);
    compared++;
    if ({out_valid, in_ready} !== 2'b10) begin
      mism++;
      $display("FAIL full_resolve: got ov=%b ir=%b, want 1 0", out_valid, in_ready);
    end
    tick();
    @(negedge clk);
    compared++;
    if ({in_ready, count} !== {1'b1, 3'd3}) begin
      mism++;
      $display("FAIL full_release: got ir=%b cnt=%0d, want 1 3", in_ready, count);
    end
    tick();
    put(3'd3, 32'h1050, 32'h5000, 1'b1, 32'h5000, 1'b0, 32'hFFFFFFF0, 1'b0, 32'd0, 32'hFFFFFFF0, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    drain();
  endtask
  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(3'd2, 32'h2000 + i * 4, 32'h2100, 1'b0, 32'h0, 1'b0, 32'd1, 1'b0, 32'd0, 32'd1, 32'd0, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (count !== 3'd3) begin
      mism++;
      $display("FAIL flush_pre: got cnt=%0d, want 3", count);
    end
    out_ready = 1'b1;
    flush = 1'b1;
    put(3'd0, 32'h2FF0, 32'h2FF8, 1'b0, 32'h0, 1'b0, 32'd1, 1'b0, 32'd1, 32'd1, 32'd1, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if ({count, out_valid, in_ready, out_pc} !== {3'd0, 1'b0, 1'b1, 32'd0}) begin
        mism++;
        $display("FAIL flush%0d: got cnt=%0d ov=%b ir=%b pc=%h, want 0 0 1 0", i, count, out_valid, in_ready, out_pc);
      end
      tick();
    end
  endtask
  task automatic test_stall();
    out_ready = 1'b0;
    put(3'd2, 32'h500, 32'h900, 1'b1, 32'h900, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_taken, out_target, out_pc, count} !== {1'b1, 1'b0, 32'h504, 32'h500, 3'd1}) begin
        mism++;
        $display("FAIL stall%0d: got ov=%b tk=%b tgt=%h pc=%h cnt=%0d, want 1 0 00000504 00000500 1",
                 i, out_valid, out_taken, out_target, out_pc, count);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    compared++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      mism++;
      $display("FAIL stall_release: got ov=%b cnt=%0d, want 0 0", out_valid, count);
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] ks [9] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd2, 3'd5, 3'd0, 3'd7, 3'd4};
    logic [31:0] as [9] = '{32'd3, 32'd1, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'd1, 32'd4, 32'd0};
    logic [31:0] bs [9] = '{32'd3, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd4, 32'd0};
    logic [31:0] p;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      p = ks[i] == 3'd7 ? 32'hFFFFFFFC : 32'h6000 + i * 8;
      put(ks[i], p, 32'h7000 + i * 16, i[0], 32'h7000 + i * 16, 1'b0, as[i], 1'b0, bs[i], as[i], bs[i], 1'b1);
      tick();
    end
    in_valid = 1'b0;
    drain();
  endtask
  initial begin
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cdb_valid = '0;
    cdb_rsid = '0;
    cdb_data = '0;
    test_reset();
    test_beq();
    test_cdb_capture();
    test_bypass();
    test_full_wrap();
    test_flush();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 SHALL have parameter CDB_NUM, default 2, result-broadcast channel count.
REQ-003 SHALL have parameter RSID_WIDTH, default 4, reservation-station ID width; data/address width fixed at 32.
REQ-004 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: flush input 1 discard all entries; in_valid input 1; in_ready output 1.
REQ-006 SHALL have ports: in_kind input 3 condition (0 EQ, 1 NE, 2 GTZ, 3 LEZ, 4 LTZ, 5 GEZ, 6 JR; 7 reserved); in_pc input 32; in_target input 32 branch target (ignored for JR).
REQ-007 SHALL have ports: in_pred_taken input 1; in_pred_target input 32 predicted fetch target.
REQ-008 SHALL have ports: in_op1_is_rsid, in_op2_is_rsid input 1 each; in_op1, in_op2 input 32 each (data, or RSID in low RSID_WIDTH bits when is_rsid).
REQ-009 SHALL have ports: cdb_valid input CDB_NUM; cdb_rsid input CDB_NUM*RSID_WIDTH; cdb_data input CDB_NUM*32 (channel i at slice i).
REQ-010 SHALL have ports: out_valid output 1; out_ready input 1; out_pc output 32; out_taken output 1; out_target output 32 resolved next PC; out_mispredict output 1; count output log2(DEPTH)+1.

Function
REQ-011 SHALL hold branches in FIFO order; only head entry resolves and leaves.
REQ-012 SHALL set in_ready = (count < DEPTH), independent of out_ready (no full-queue enqueue/dequeue bypass).
REQ-013 SHALL enqueue on in_valid && in_ready at clock edge; count +1, -1, or unchanged when enqueue and dequeue coincide.
REQ-014 SHALL capture CDB per pending operand each cycle: cdb_valid[i] && cdb_rsid[i] == stored RSID -> store cdb_data[i], mark ready; lowest matching i wins.
REQ-015 SHALL apply REQ-014 to operands being enqueued in the same cycle (enqueue-time bypass); entry then stored ready.
REQ-016 SHALL ignore op2 readiness for GTZ, LEZ, LTZ, GEZ, JR.
REQ-017 SHALL assert out_valid combinationally from registered state only: head valid and its required operands ready.
REQ-018 SHALL compute taken: EQ op1==op2; NE op1!=op2; GTZ signed op1>0; LEZ signed op1<=0; LTZ op1[31]; GEZ !op1[31]; JR 1.
REQ-019 SHALL compute out_target: JR -> op1; else taken -> stored in_target; not taken -> pc+4 (32-bit wrap).
REQ-020 SHALL compute out_mispredict = (out_taken != pred_taken) || (out_taken && out_target != pred_target).
REQ-021 SHALL dequeue head on out_valid && out_ready; outputs stable while out_valid && !out_ready.
REQ-022 SHALL give latency: enqueue with ready operands into empty queue at edge N -> out_valid during cycle N+1; CDB capture at edge M -> out_valid during cycle M+1 if entry is head.
REQ-023 SHALL wrap read/write pointers modulo DEPTH.
REQ-024 SHALL on flush clear all entries, count=0, out_valid=0 next cycle; flush beats simultaneous enqueue and dequeue (enqueued entry discarded).
REQ-025 SHALL treat in_kind 7 as resolved not-taken, out_target=pc+4.

Reset
REQ-026 SHALL, when rst==0 at clock edge, clear all valid/ready flags and pointers; count=0, out_valid=0, in_ready=1.
REQ-027 SHALL drive out_pc, out_target to 0 and out_taken, out_mispredict to 0 whenever out_valid==0.
REQ-028 SHALL let reset mid-operation discard all entries, including one being enqueued that cycle.

Verification
REQ-029 BEQ op1=5, op2=5 ready, pc=0x100, target=0x200, pred_taken=0, pred_target=0x104 -> next cycle out_valid=1, taken=1, out_target=0x200, mispredict=1.
REQ-030 BLTZ op1 is_rsid=3; two cycles later cdb_valid=01, rsid0=3, data0=0xFFFFFFFF -> next cycle taken=1, out_valid=1; nothing earlier.
REQ-031 JR op1 rsid=2, same-cycle cdb channel 1 rsid=2 data=0x4000 at enqueue -> next cycle out_target=0x4000, taken=1.
REQ-032 DEPTH=4: enqueue 4 with head unresolved, out_ready=1 -> in_ready=0 at count 4; 5th held; resolve head -> in_ready=1 next cycle; FIFO order through pointer wrap over 6 branches.
REQ-033 Queue count=3, flush=1 with in_valid=1 and head dequeue -> count=0, out_valid=0 next cycle.
REQ-034 BGTZ op1=0 ready, out_ready=0 for 3 cycles -> out_valid held, taken=0, out_target=pc+4 stable; dequeue on 4th cycle.
